// File: rtl/tdm_demux_1to8_pkg.sv
// Shared constants, types and helpers for the 1-to-8 TDM demultiplexer.
// The slot index width and channel count are tied together here.
package tdm_demux_1to8_pkg;

  localparam int NUM_CH = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

  // Quarter-decoder used by both halves of the write-enable tree.
  function automatic logic [3:0] dec_1to4(input logic en, input logic [1:0] sel);
    logic [3:0] r;
    r      = '0;
    r[sel] = en;
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// Bundle of the slot-serial input stream and the demultiplexed outputs.
// The demux itself takes the slave view; whatever feeds it takes the master view.
interface tdm_demux_1to8_if
  import tdm_demux_1to8_pkg::*;
#(
  parameter int DW = 1
);

  logic [DW-1:0]        din;
  logic                 din_valid;
  logic                 sof;
  logic [NUM_CH*DW-1:0] ch_out;
  logic [NUM_CH-1:0]    ch_strobe;
  logic [NUM_CH*DW-1:0] frame_out;
  logic                 frame_valid;
  logic                 locked;
  logic                 sync_err;
  slot_t                slot;

  modport master (
    output din, din_valid, sof,
    input  ch_out, ch_strobe, frame_out, frame_valid, locked, sync_err, slot
  );

  modport slave (
    input  din, din_valid, sof,
    output ch_out, ch_strobe, frame_out, frame_valid, locked, sync_err, slot
  );

endinterface

// File: rtl/tdm_demux_1to8_dec.sv
// Slot index plus enable to one-hot write-enable: a 1:2 split on the top
// index bit feeding two 1:4 quarter decoders.
module demux_1to8_dec
  import tdm_demux_1to8_pkg::*;
(
  input  slot_t             idx,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  logic en_lo;
  logic en_hi;

  assign en_lo  = en & ~idx[2];
  assign en_hi  = en &  idx[2];
  assign onehot = {dec_1to4(en_hi, idx[1:0]), dec_1to4(en_lo, idx[1:0])};

endmodule

// File: rtl/tdm_demux_1to8.sv
// Registered 1-to-8 TDM demultiplexer: locks on sof, steers each accepted
// beat into its channel register and publishes every complete 8-slot frame.
module tdm_demux_1to8
  import tdm_demux_1to8_pkg::*;
#(
  parameter int DW = 1
)(
  input  logic             clk,
  input  logic             rst,
  tdm_demux_1to8_if.slave  bus
);

  state_t               state_q, state_d;
  slot_t                slot_q, slot_d;
  slot_t                wr_idx;
  logic                 wr_req;
  logic                 err_d;
  logic                 frame_done_d;
  logic [NUM_CH-1:0]    wr_en;

  logic [NUM_CH*DW-1:0] ch_q;
  logic [NUM_CH*DW-1:0] frame_q;
  logic [NUM_CH-1:0]    strobe_q;
  logic                 frame_valid_q;
  logic                 sync_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // LOCKED is sticky; only rst returns to HUNT.
  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && bus.din_valid && bus.sof) state_d = LOCKED;
  end

  // NOTE: every signal gets a default before any branch, otherwise a missed
  // path in always_comb infers a latch.
  always_comb begin
    wr_req       = 1'b0;
    wr_idx       = slot_q;
    slot_d       = slot_q;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sof) begin
            wr_req = 1'b1;
            wr_idx = '0;
          end
        end
        LOCKED: begin
          wr_req = 1'b1;
          if (bus.sof) begin
            // A resync abandons the partial frame and restarts at slot 0.
            wr_idx = '0;
            err_d  = (slot_q != '0);
          end else begin
            frame_done_d = (slot_q == slot_t'(NUM_CH - 1));
          end
        end
        default: ;
      endcase
    end
    if (wr_req) slot_d = wr_idx + slot_t'(1);
  end

  demux_1to8_dec u_dec (
    .idx    (wr_idx),
    .en     (wr_req),
    .onehot (wr_en)
  );

  // NOTE: the channel and frame registers are cleared by reset because their
  // reset value of zero is observable on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= '0;
      ch_q          <= '0;
      frame_q       <= '0;
      strobe_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      strobe_q      <= wr_en;
      frame_valid_q <= frame_done_d;
      sync_err_q    <= err_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) ch_q[k*DW +: DW] <= bus.din;
      end
      // Slot 7 bypasses its own channel register so the frame lands this edge.
      if (frame_done_d) frame_q <= {bus.din, ch_q[(NUM_CH-1)*DW-1:0]};
    end
  end

  assign bus.ch_out      = ch_q;
  assign bus.ch_strobe   = strobe_q;
  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == LOCKED);

endmodule
